// File: rtl/mmm_nlp_90b.sv
// rtl/mmm_nlp_90b.sv - exact unsigned IDW x IDW multiplier built from OAW x OBW tiles
module mmm_nlp_90b #(
  parameter int ODW = 180,
  parameter int IDW = 90,
  parameter int OAW = 24,
  parameter int OBW = 16
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  output logic [ODW-1:0] o_res
);

  // Tile counts and padded widths; the top slices are zero-filled when IDW
  // is not a multiple of the tile width.
  localparam int NA  = (IDW + OAW - 1) / OAW;
  localparam int NB  = (IDW + OBW - 1) / OBW;
  localparam int PAW = NA * OAW;
  localparam int PBW = NB * OBW;
  localparam int PPW = OAW + OBW;
  localparam int ACW = PAW + PBW;
  localparam int NPP = NA * NB;

  logic [PAW-1:0] w_a_ext;
  logic [PBW-1:0] w_b_ext;
  logic [PPW-1:0] w_pp   [NPP];
  logic [ACW-1:0] w_term [NPP];
  logic [ACW-1:0] w_acc;

  assign w_a_ext = PAW'(i_a);
  assign w_b_ext = PBW'(i_b);

  // One small multiplier per (a slice, b slice) pair, each placed at its
  // combined bit offset so the final sum needs no further alignment.
  for (genvar gi = 0; gi < NA; gi++) begin : g_a
    for (genvar gj = 0; gj < NB; gj++) begin : g_b
      assign w_pp[gi*NB+gj] = PPW'(w_a_ext[gi*OAW +: OAW]) *
                              PPW'(w_b_ext[gj*OBW +: OBW]);
      assign w_term[gi*NB+gj] = ACW'(w_pp[gi*NB+gj]) << (gi*OAW + gj*OBW);
    end
  end

  // Linear sum of the aligned partial products; carries ripple across all
  // tile seams inside the wide adder chain.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NPP; k++) begin
      w_acc = w_acc + w_term[k];
    end
  end

  // The product of two IDW-bit values fits in 2*IDW bits, so the bits above
  // ODW are always zero and are dropped here.
  assign o_res = w_acc[ODW-1:0];

  // Clock and reset are reserved ports with no state behind them yet.
  logic w_unused;
  assign w_unused = &{1'b0, i_clk, i_rstn, w_acc[ACW-1:ODW]};

endmodule

// File: tb/tb_mmm_nlp_90b.sv
// tb/tb_mmm_nlp_90b.sv - self-checking bench for mmm_nlp_90b
module tb_mmm_nlp_90b;

  localparam int IDW = 90;
  localparam int ODW = 180;

  logic           i_clk = 1'b0;
  logic           i_rstn;
  logic [IDW-1:0] i_a;
  logic [IDW-1:0] i_b;
  logic [ODW-1:0] o_res;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 i_clk = ~i_clk;

  mmm_nlp_90b #(.ODW(ODW), .IDW(IDW), .OAW(24), .OBW(16)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_res  (o_res)
  );

  // Golden: plain wide multiplication of the applied operands.
  function automatic logic [ODW-1:0] model(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    logic [ODW-1:0] wa;
    logic [ODW-1:0] wb;
    wa = ODW'(a);
    wb = ODW'(b);
    return wa * wb;
  endfunction

  task automatic compare(input string name, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every cycle, check the output against the model away from the drive edge.
  always @(negedge i_clk) begin
    if (chk_en) compare("model", o_res, model(i_a, i_b));
  end

  task automatic apply(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    @(posedge i_clk);
    i_a = a;
    i_b = b;
  endtask

  task automatic lit(input string name, input logic [ODW-1:0] exp);
    @(negedge i_clk);
    #1;
    compare(name, o_res, exp);
  endtask

  logic [IDW-1:0] ones;
  logic [IDW-1:0] ra;
  logic [IDW-1:0] rb;
  logic [ODW-1:0] max_prod;
  logic [95:0]    raw;

  initial begin
    ones     = {IDW{1'b1}};
    max_prod = {{89{1'b1}}, {90{1'b0}}, 1'b1};
    i_a    = '0;
    i_b    = '0;
    i_rstn = 1'b0;
    repeat (2) @(posedge i_clk);
    lit("reset_state", 180'h0);
    @(posedge i_clk);
    i_rstn = 1'b1;
    chk_en = 1'b1;

    apply('0, ones);
    lit("zero_times_ones", 180'h0);
    apply(ones, '0);
    lit("ones_times_zero", 180'h0);
    apply(90'h1, 90'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA);
    lit("one_times_b", 180'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA);
    apply(ones, ones);
    lit("all_ones", max_prod);
    apply(90'hFF_FFFF, 90'hFFFF);
    lit("seam_24x16", 180'hFF_FEFF_0001);
    apply(90'hFFFF_FFFF_FFFF, 90'hFFFF_FFFF);
    lit("seam_48x32", 180'hFFFF_FFFE_FFFF_0000_0001);
    apply(90'h1 << 89, 90'h1 << 89);
    lit("top_bits", 180'h1 << 178);

    // Random regression: top 26 bits of each operand reduced mod 2^26-1.
    for (int n = 0; n < 10000; n++) begin
      raw = {$urandom, $urandom, $urandom};
      ra  = raw[IDW-1:0];
      ra[89:64] = ra[89:64] % 26'd67108863;
      raw = {$urandom, $urandom, $urandom};
      rb  = raw[IDW-1:0];
      rb[89:64] = rb[89:64] % 26'd67108863;
      apply(ra, rb);
    end

    // Reset pulse with operands held: output must stay the exact product.
    apply(90'h123456789ABCDEF012345, 90'hFEDCBA9876543210FEDCB);
    lit("pre_reset", model(90'h123456789ABCDEF012345, 90'hFEDCBA9876543210FEDCB));
    #2 i_rstn = 1'b0;
    lit("during_reset", model(90'h123456789ABCDEF012345, 90'hFEDCBA9876543210FEDCB));
    repeat (2) @(posedge i_clk);
    #3 i_rstn = 1'b1;
    lit("after_reset", model(90'h123456789ABCDEF012345, 90'hFEDCBA9876543210FEDCB));
    repeat (2) @(posedge i_clk);

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmm_nlp_90b.md
Name: mmm_nlp_90b

Overview:
- Unsigned 90x90-bit integer multiplier producing the exact 180-bit product.
- Product is built from a tiled array of small OAW x OBW (24x16) partial-product multipliers, sized for DSP-style slices, then summed with shifts.
- Serves as the wide-multiply core of the modular-multiplication (MMM) datapath.

Parameters:
- ODW, 180, product width; must equal 2*IDW.
- IDW, 90, width of each operand.
- OAW, 24, tile width of the operand-A slice in each partial multiplier.
- OBW, 16, tile width of the operand-B slice in each partial multiplier.

Ports:
- i_clk  input  1  system clock; reserved, no state is clocked in this revision.
- i_rstn  input  1  reset, asynchronous, active-low; reserved, no state to reset.
- i_a  input  IDW  multiplicand, unsigned.
- i_b  input  IDW  multiplier, unsigned.
- o_res  output  ODW  product i_a*i_b, unsigned.

Interface: one clock (i_clk); reset i_rstn is asynchronous and active-low.

Behaviour:
- Function: o_res = i_a * i_b, exact unsigned, no truncation. The full 180 bits are always valid because (2^90-1)^2 < 2^180.
- Latency: zero. The path is purely combinational, and o_res settles within the same cycle the inputs change.
- No registers, no handshake, no valid signal. New operands may be applied every cycle.
- Reset has no effect on o_res. Asserting or deasserting i_rstn mid-operation does not disturb the output. There are no internal states, so no reset value is defined.
- Decomposition:
  - Zero-extend i_a to ceil(IDW/OAW)*OAW = 96 bits, giving 4 slices a_i of 24 bits.
  - Zero-extend i_b to ceil(IDW/OBW)*OBW = 96 bits, giving 6 slices b_j of 16 bits.
  - Form 24 partial products p_ij = a_i*b_j, each 40 bits unsigned.
  - Sum p_ij << (i*OAW + j*OBW) into an accumulator of at least 192 bits.
  - o_res = accumulator[ODW-1:0]. The upper bits are provably zero.
- Parameter generality: slice counts derive from the parameters via generate loops. Zero-extension pads the top slices when IDW is not a multiple of OAW/OBW.
- Adder structure (tree or linear) is implementer's choice. Bit-exactness against a*b is mandatory.
- Boundaries:
  - Zero times anything gives 0.
  - All-ones operands produce the maximum product with no overflow.
  - Carries must propagate across every tile boundary.

Test Plan:
- a=0, b=0x3FF_FFFF_FFFF_FFFF_FFFF_FFFF (all ones) -> o_res=0. Repeat with operands swapped -> o_res=0.
- a=1, b=0x2AA_AAAA_AAAA_AAAA_AAAA_AAAA -> o_res equals b, zero-extended to 180 bits.
- a=b=2^90-1 -> o_res = 2^180 - 2^91 + 1, i.e. 0xFFF...FE000...001, where 1 is in bit 0 and bits 91..179 are ones.
- Tile-boundary carries: a=2^24-1, b=2^16-1 -> 0xFFFEFF0001. Then a=2^48-1, b=2^32-1 -> exact product; checks carry across the a_0/a_1 and b_1/b_2 seams.
- Random regression:
  - Apply new random a, b every clock; top 26 bits of each operand reduced mod 67108863.
  - 10000 cycles after reset, compare o_res with the golden a*b in the same cycle -> zero mismatches.
- Reset pulse: with a=0x123456789ABCDEF012345, b=0xFEDCBA9876543210FEDCB held, drive i_rstn low for 2 cycles then high -> o_res remains the exact product throughout.
